// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to one-port memory bus arbiter; zero-wait latency is request -> ack in 3 cycles, one transaction per 4 cycles.
// Requesters hold req until ack and see stall while waiting; the bus applies backpressure via mem_gnt and completes via mem_rvalid or timeout.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_bwe,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_bwe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          owner;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;
  logic          pick_d;
  logic          pick_i;
  logic          to_hit;

  // Data normally wins; a fetch starved for STARVE_LIMIT data grants takes the next slot.
  assign pick_d = d_req && !(i_req && (starve_cnt == STARVE_MAX));
  assign pick_i = i_req && !pick_d;
  assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  assign mem_req   = (state == REQ);
  assign i_ack     = (state == RESP) && (owner == OWN_I);
  assign d_ack     = (state == RESP) && (owner == OWN_D);
  assign stall_if  = i_req && !i_ack;
  assign stall_mem = d_req && !d_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      starve_cnt <= '0;
      to_cnt     <= '0;
      mem_we     <= 1'b0;
      mem_bwe    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= REQ;
            owner     <= OWN_D;
            mem_we    <= d_we;
            mem_bwe   <= d_bwe;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!i_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (pick_i) begin
            state      <= REQ;
            owner      <= OWN_I;
            mem_we     <= 1'b0;
            mem_bwe    <= '0;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state  <= WAIT;
            to_cnt <= '0;
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          // A completion arriving in the timeout cycle still counts as success.
          if (mem_rvalid) begin
            state <= RESP;
            if (owner == OWN_I) begin
              i_rdata <= mem_rdata;
              i_err   <= 1'b0;
            end else begin
              if (!mem_we)
                d_rdata <= mem_rdata;
              d_err <= 1'b0;
            end
          end else if (to_hit) begin
            state <= RESP;
            if (owner == OWN_I)
              i_err <= 1'b1;
            else
              d_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected acks and bus requests, monitors pop and compare.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_bwe, d_addr, d_wdata;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_bwe, mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_bwe(d_bwe), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_bwe(mem_bwe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] bwe;
    logic [31:0] wdata;
  } bus_t;

  ack_t ack_q[$];
  bus_t bus_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t0;

  // Bus responder controls
  logic        rv_en    = 1'b1;
  logic        late_rv  = 1'b0;
  int          gnt_wait = 0;
  int          req_age  = 0;
  logic        pending  = 1'b0;
  logic [31:0] pend_addr = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic void exp_ack(input logic is_d, input logic [31:0] rd, input logic err, input int c);
    ack_t e;
    e.is_d = is_d; e.rdata = rd; e.err = err; e.cyc = c;
    ack_q.push_back(e);
  endfunction

  function automatic void exp_bus(input logic [31:0] a, input logic we, input logic [31:0] bwe, input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.we = we; b.bwe = bwe; b.wdata = wd;
    bus_q.push_back(b);
  endfunction

  // Memory model: grant after gnt_wait request cycles, complete on the following cycle.
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (pending && rv_en) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_val(pend_addr);
    end
    if (late_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_0000;
    end
    pending = 1'b0;
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (req_age >= gnt_wait) begin
        mem_gnt   = 1'b1;
        pending   = 1'b1;
        pend_addr = mem_addr;
        req_age   = 0;
      end else begin
        req_age++;
      end
    end
  end

  ack_t e;
  bus_t cur;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      if (ack_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_ack: i_ack=%b d_ack=%b but none required (cycle %0d)", i_ack, d_ack, cyc);
      end else begin
        e = ack_q.pop_front();
        chk("ack_port", {i_ack, d_ack}, {!e.is_d, e.is_d});
        chk("ack_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        chk("ack_err", e.is_d ? d_err : i_err, e.err);
        chk("ack_cycle", cyc, e.cyc);
      end
    end
    if (mem_req) begin
      if (!prev_req) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_req: mem_addr=%h but no request required (cycle %0d)", mem_addr, cyc);
          cur.addr = 'x; cur.we = 'x; cur.bwe = 'x; cur.wdata = 'x;
        end else begin
          cur = bus_q.pop_front();
        end
      end
      chk("bus_addr", mem_addr, cur.addr);
      chk("bus_we", mem_we, cur.we);
      chk("bus_bwe", mem_bwe, cur.bwe);
      chk("bus_wdata", mem_wdata, cur.wdata);
      chk("ack_with_req", i_ack | d_ack, 1'b0);
    end
    prev_req = mem_req;
  end

  task automatic wait_ack(input logic is_d);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      if (is_d ? d_ack : i_ack) break;
      n++;
    end
    if (n == 100) begin
      total++; bad++;
      $display("FAIL ack_wait: no %s ack within 100 cycles, got none expected one", is_d ? "d" : "i");
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_i(input logic [31:0] a);
    i_req = 1'b1; i_addr = a;
    wait_ack(1'b0);
    i_req = 1'b0;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic we, input logic [31:0] bwe,
                         input logic [31:0] wd, input logic hold);
    d_req = 1'b1; d_addr = a; d_we = we; d_bwe = bwe; d_wdata = wd;
    wait_ack(1'b1);
    if (!hold) begin
      d_req = 1'b0; d_we = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_bwe = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ctrl", {mem_req, mem_we, i_ack, d_ack, i_err, d_err}, 6'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_bwe", mem_bwe, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch with zero-wait memory
    t0 = cyc;
    exp_ack(1'b0, 32'h0050_0093, 1'b0, t0 + 3);
    exp_bus(32'h100, 1'b0, 32'h0, 32'h0);
    fork
      drive_i(32'h100);
      begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("fetch_stall_if", stall_if, c < 3);
          chk("fetch_mem_req", mem_req, c == 1);
        end
      end
    join

    // Fetch and load together: data first, fetch four cycles later
    t0 = cyc;
    exp_ack(1'b1, 32'h5A5A_2000, 1'b0, t0 + 3);
    exp_ack(1'b0, 32'h0050_0093, 1'b0, t0 + 7);
    exp_bus(32'h2000, 1'b0, 32'h0, 32'h0);
    exp_bus(32'h100, 1'b0, 32'h0, 32'h0);
    fork
      drive_d(32'h2000, 1'b0, 32'h0, 32'h0, 1'b0);
      drive_i(32'h100);
      begin
        repeat (4) @(negedge clk);
        chk("both_stall_mem", stall_mem, 1'b0);
        chk("both_stall_if", stall_if, 1'b1);
      end
    join

    // Store with a slow grant: fields held through REQ, d_rdata untouched
    gnt_wait = 2;
    t0 = cyc;
    exp_ack(1'b1, 32'h5A5A_2000, 1'b0, t0 + 5);
    exp_bus(32'h40, 1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF);
    drive_d(32'h40, 1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0);
    gnt_wait = 0;

    // Timeout: eight WAIT cycles then error ack, late rvalid ignored
    rv_en = 1'b0;
    t0 = cyc;
    exp_ack(1'b1, 32'h5A5A_2000, 1'b1, t0 + 10);
    exp_bus(32'h80, 1'b0, 32'h0, 32'h0);
    drive_d(32'h80, 1'b0, 32'h0, 32'h0, 1'b0);
    late_rv = 1'b1;
    repeat (2) @(posedge clk);
    #1 late_rv = 1'b0;
    @(negedge clk);
    chk("late_rv_rdata", d_rdata, 32'h5A5A_2000);
    chk("late_rv_req", mem_req, 1'b0);
    rv_en = 1'b1;
    @(posedge clk); #1;

    // Starvation: four data grants, one fetch, then data again
    t0 = cyc;
    for (int n = 0; n < 4; n++) begin
      exp_ack(1'b1, 32'h5A5A_3000 + 32'(n * 4), 1'b0, t0 + 3 + 4 * n);
      exp_bus(32'h3000 + 32'(n * 4), 1'b0, 32'h0, 32'h0);
    end
    exp_ack(1'b0, 32'h5A5A_0104, 1'b0, t0 + 19);
    exp_bus(32'h104, 1'b0, 32'h0, 32'h0);
    exp_ack(1'b1, 32'h5A5A_3010, 1'b0, t0 + 23);
    exp_bus(32'h3010, 1'b0, 32'h0, 32'h0);
    fork
      begin
        for (int n = 0; n < 5; n++)
          drive_d(32'h3000 + 32'(n * 4), 1'b0, 32'h0, 32'h0, n < 4);
      end
      drive_i(32'h104);
    join

    // Reset while waiting for the bus, then a clean fetch
    rv_en = 1'b0;
    exp_bus(32'h200, 1'b0, 32'h0, 32'h0);
    i_req = 1'b1; i_addr = 32'h200;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstw_ctrl", {mem_req, mem_we, i_ack, d_ack, i_err, d_err}, 6'b0);
    chk("rstw_addr", mem_addr, 32'h0);
    chk("rstw_i_rdata", i_rdata, 32'h0);
    chk("rstw_d_rdata", d_rdata, 32'h0);
    i_req = 1'b0;
    rv_en = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    exp_ack(1'b0, 32'h0050_0093, 1'b0, t0 + 3);
    exp_bus(32'h100, 1'b0, 32'h0, 32'h0);
    drive_i(32'h100);

    repeat (2) @(posedge clk);
    chk("ack_q_left", ack_q.size(), 32'd0);
    chk("bus_q_left", bus_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter for the RV32 pipeline. It lets the IF-stage instruction fetch port and the MEM-stage load/store port share a single-ported memory bus. It grants one requester at a time and runs a req/gnt/rvalid transaction on the bus. It returns data and a one-cycle ack to the winner, and drives stall outputs that the hazard logic ORs into its pipeline stalls.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch is pending; the next grant then goes to the fetch port.
- TIMEOUT, default 256: maximum number of WAIT cycles before the transaction is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  fetched instruction; valid with i_ack, held until the next fetch ack.
- i_err  out  1  timeout flag; valid only with i_ack.
- d_req  in  1  load/store request; held high until d_ack.
- d_we  in  1  1 = store.
- d_bwe  in  32  per-bit write enable.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load data; updated only on a load ack.
- d_err  out  1  timeout flag; valid only with d_ack.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_bwe  out  32  bus bit write enables.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_gnt  in  1  bus accepts the request in the current cycle.
- mem_rvalid  in  1  bus completion (read data or write done).
- mem_rdata  in  32  bus read data.
- stall_if  out  1  i_req & ~i_ack (combinational).
- stall_mem  out  1  d_req & ~d_ack (combinational).

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Owner register: I or D.
- IDLE:
  - Select a winner: D if d_req, unless i_req is also high and starve_cnt == STARVE_LIMIT, in which case I. Otherwise I if i_req alone.
  - Latch the winner's addr, we, bwe and wdata into the bus registers; fetch uses we=0, bwe=0, wdata=0.
  - Go to REQ. With no request, stay in IDLE.
- REQ: mem_req=1 with the latched fields, which stay stable. On mem_gnt go to WAIT. mem_rvalid in REQ is ignored.
- WAIT: mem_req=0; the timeout counter increments each cycle.
  - On mem_rvalid: capture mem_rdata into the owner's rdata register (D only if it is a load), clear err, go to RESP.
  - If the counter reaches TIMEOUT first: rdata is left unchanged, err=1, go to RESP.
  - mem_rvalid and the timeout in the same cycle: rvalid wins, err=0.
- RESP: assert the owner's ack for exactly one cycle, with no arbitration in this cycle, then go to IDLE. The requester may drop or change its request from the next cycle.
- starve_cnt (width clog2(STARVE_LIMIT+1)), updated at each grant:
  - D granted while i_req=1: increment, saturating.
  - I granted: clear.
  - D granted while i_req=0: clear.
- One outstanding transaction at a time. Requests are not cancellable.
- The bus timeout counter clears on entry to WAIT.

## Timing
- Reset values:
  - State IDLE, owner I.
  - mem_req, mem_we, i_ack, d_ack, i_err, d_err = 0.
  - mem_bwe, mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - starve_cnt and the timeout counter = 0.
- Reset asserted mid-transaction abandons the transaction immediately. A later mem_rvalid seen in IDLE is ignored.
- With zero-wait memory (gnt during REQ, rvalid on the first WAIT cycle): request sampled in cycle 0, mem_req in cycle 1, WAIT in cycle 2, ack in cycle 3.
- Back-to-back throughput is one transaction every 4 cycles.
- A fetch and a load requested together in cycle 0: d_ack in cycle 3, then i_ack in cycle 7.
- An ack never asserts in the same cycle as mem_req.

## Test plan
- Single fetch: i_req=1, i_addr=0x100, gnt immediate, rvalid the next cycle with 0x00500093 -> mem_req only in cycle 1, i_ack in cycle 3, i_rdata=0x00500093, stall_if high in cycles 0-2.
- Simultaneous fetch and load, d_addr=0x2000 -> bus serves 0x2000 first; d_ack in cycle 3, i_ack in cycle 7.
- Store: d_we=1, d_bwe=0x0000FFFF, d_wdata=0xDEADBEEF -> mem_we=1 with those fields stable through REQ; d_rdata unchanged after d_ack.
- Starvation: d_req held high with a new address every transaction, i_req high, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then data again.
- Timeout: TIMEOUT=8, gnt given, rvalid never arrives -> d_ack with d_err=1 after 8 WAIT cycles; a late rvalid seen in IDLE is ignored.
- Reset in WAIT: assert rst mid-transaction -> all outputs 0 immediately; a new fetch after deassert completes normally.
